// File: rtl/memory_bus_write_sequencer_if.sv
// Request channel and BRAM write-bus signals of the write sequencer.
// slave = sequencer view, master = requester/observer view.
interface memory_bus_write_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [1:0]  req_select;
  logic [17:0] req_addr;
  logic [15:0] req_data;
  logic        bus_en;
  logic        bus_we;
  logic [1:0]  bus_select;
  logic [13:0] bus_addr;
  logic [15:0] bus_data;

  modport slave (
    input  req_valid, req_kind, req_select, req_addr, req_data,
    output req_ready, bus_en, bus_we, bus_select, bus_addr, bus_data
  );

  modport master (
    output req_valid, req_kind, req_select, req_addr, req_data,
    input  req_ready, bus_en, bus_we, bus_select, bus_addr, bus_data
  );
endinterface

// File: rtl/memory_bus_write_sequencer.sv
// BRAM write master: direct writes plus STM / duty-table linear writes with page-register writes.
// Define BUS_SEQ_PAGE_CACHE_EN to skip page writes whose page is already cached.
module memory_bus_write_sequencer #(
  parameter int unsigned WE_CYCLES               = 2,
  parameter logic [13:0] ADDR_STM_MEM_WR_PAGE    = 14'h0000,
  parameter logic [13:0] ADDR_DUTY_TABLE_WR_PAGE = 14'h0000,
  parameter logic [1:0]  BRAM_SELECT_CONTROLLER  = 2'd0,
  parameter logic [1:0]  BRAM_SELECT_STM         = 2'd3
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                page_invalidate_i,
  memory_bus_write_sequencer_if.slave         mb,
  output logic                                done_o,
  output logic                                err_o
);
  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);
  localparam logic [1:0] K_DIRECT = 2'd0, K_STM = 2'd1, K_DUTY = 2'd2, K_RSVD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_PG_SETUP, S_PG_STROBE, S_PG_HOLD, S_SETUP, S_STROBE, S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  kind_q, kind_d;
  logic [3:0]  page_q, page_d;
  logic [1:0]  dsel_q, dsel_d;
  logic [13:0] daddr_q, daddr_d;
  logic [15:0] ddata_q, ddata_d;
  logic [1:0]  bsel_q, bsel_d;
  logic [13:0] baddr_q, baddr_d;
  logic [15:0] bdata_q, bdata_d;
  logic        done_q, done_d, err_q, err_d;

  // Request decode, used only at acceptance
  logic [1:0]  acc_sel;
  logic [13:0] acc_addr;
  logic [3:0]  acc_page;
  logic [13:0] pg_addr;
  logic        need_pg;

  always_comb begin
    acc_sel  = mb.req_select;
    acc_addr = mb.req_addr[13:0];
    acc_page = mb.req_addr[17:14];
    pg_addr  = ADDR_STM_MEM_WR_PAGE;
    if (mb.req_kind == K_STM) begin
      acc_sel = BRAM_SELECT_STM;
    end else if (mb.req_kind == K_DUTY) begin
      acc_sel  = BRAM_SELECT_CONTROLLER;
      acc_addr = {2'b00, 1'b1, mb.req_addr[12:0]};
      acc_page = {2'b00, mb.req_addr[14:13]};
      pg_addr  = ADDR_DUTY_TABLE_WR_PAGE;
    end
  end

`ifdef BUS_SEQ_PAGE_CACHE_EN
  logic [3:0] stm_pg_q, stm_new;
  logic [1:0] duty_pg_q, duty_new;
  logic       stm_vld_q, duty_vld_q, stm_upd, duty_upd;

  // Page-phase completion or a direct write that lands on a page register
  always_comb begin
    stm_upd  = 1'b0;
    duty_upd = 1'b0;
    stm_new  = page_q;
    duty_new = page_q[1:0];
    if (state_q == S_PG_HOLD) begin
      stm_upd  = (kind_q == K_STM);
      duty_upd = (kind_q == K_DUTY);
    end else if (state_q == S_HOLD && kind_q == K_DIRECT && dsel_q == BRAM_SELECT_CONTROLLER) begin
      stm_upd  = (daddr_q == ADDR_STM_MEM_WR_PAGE);
      duty_upd = (daddr_q == ADDR_DUTY_TABLE_WR_PAGE);
      stm_new  = ddata_q[3:0];
      duty_new = ddata_q[1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stm_pg_q   <= '0;
      duty_pg_q  <= '0;
      stm_vld_q  <= 1'b0;
      duty_vld_q <= 1'b0;
    end else begin
      if (stm_upd)  stm_pg_q  <= stm_new;
      if (duty_upd) duty_pg_q <= duty_new;
      stm_vld_q  <= !page_invalidate_i && (stm_vld_q || stm_upd);
      duty_vld_q <= !page_invalidate_i && (duty_vld_q || duty_upd);
    end
  end

  assign need_pg = (mb.req_kind == K_STM)  ? !(stm_vld_q && stm_pg_q == acc_page) :
                   (mb.req_kind == K_DUTY) ? !(duty_vld_q && duty_pg_q == acc_page[1:0]) : 1'b0;
`else
  logic unused_nocache;
  assign unused_nocache = ^{page_invalidate_i, kind_q, page_q};
  assign need_pg = (mb.req_kind == K_STM) || (mb.req_kind == K_DUTY);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    page_d  = page_q;
    dsel_d  = dsel_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;
    bsel_d  = bsel_q;
    baddr_d = baddr_q;
    bdata_d = bdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: if (mb.req_valid) begin
        if (mb.req_kind == K_RSVD) begin
          err_d = 1'b1;
        end else begin
          kind_d  = mb.req_kind;
          page_d  = acc_page;
          dsel_d  = acc_sel;
          daddr_d = acc_addr;
          ddata_d = mb.req_data;
          if (need_pg) begin
            state_d = S_PG_SETUP;
            bsel_d  = BRAM_SELECT_CONTROLLER;
            baddr_d = pg_addr;
            bdata_d = {12'h000, acc_page};
          end else begin
            state_d = S_SETUP;
            bsel_d  = acc_sel;
            baddr_d = acc_addr;
            bdata_d = mb.req_data;
          end
        end
      end
      S_PG_SETUP: begin
        state_d = S_PG_STROBE;
        cnt_d   = '0;
      end
      S_PG_STROBE: if (cnt_q == WE_LAST) state_d = S_PG_HOLD;
                   else                  cnt_d   = cnt_q + 4'd1;
      S_PG_HOLD: begin
        state_d = S_SETUP;
        bsel_d  = dsel_q;
        baddr_d = daddr_q;
        bdata_d = ddata_q;
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = '0;
      end
      S_STROBE: if (cnt_q == WE_LAST) state_d = S_HOLD;
                else                  cnt_d   = cnt_q + 4'd1;
      S_HOLD: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kind_q  <= '0;
      page_q  <= '0;
      dsel_q  <= '0;
      daddr_q <= '0;
      ddata_q <= '0;
      bsel_q  <= '0;
      baddr_q <= '0;
      bdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      page_q  <= page_d;
      dsel_q  <= dsel_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
      bsel_q  <= bsel_d;
      baddr_q <= baddr_d;
      bdata_q <= bdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // EN/WE decode straight from state so an async reset drops them at once
  assign mb.req_ready  = (state_q == S_IDLE) && rst_ni;
  assign mb.bus_en     = (state_q != S_IDLE);
  assign mb.bus_we     = (state_q == S_PG_STROBE) || (state_q == S_STROBE);
  assign mb.bus_select = bsel_q;
  assign mb.bus_addr   = baddr_q;
  assign mb.bus_data   = bdata_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_memory_bus_write_sequencer.sv
// Directed bench: each request is compared cycle by cycle against a hand-derived bus trace.
module tb_memory_bus_write_sequencer;
  localparam int          WE   = 2;
  localparam int          L    = 2 + WE;
  localparam logic [13:0] STMR = 14'h0010;
  localparam logic [13:0] DUTR = 14'h0011;
  localparam logic [1:0]  CTRL = 2'd0;
  localparam logic [1:0]  STM  = 2'd3;
`ifdef BUS_SEQ_PAGE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, inv = 1'b0;
  logic done, err;
  int checks = 0, errors = 0;
  logic [1:0]  last_sel  = '0;
  logic [13:0] last_addr = '0;
  logic [15:0] last_data = '0;

  memory_bus_write_sequencer_if mb();

  memory_bus_write_sequencer #(
    .WE_CYCLES(WE), .ADDR_STM_MEM_WR_PAGE(STMR), .ADDR_DUTY_TABLE_WR_PAGE(DUTR),
    .BRAM_SELECT_CONTROLLER(CTRL), .BRAM_SELECT_STM(STM)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .page_invalidate_i(inv), .mb(mb), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] pk(bit rdy, bit dn, bit er, bit en, bit we,
                                     logic [1:0] s, logic [13:0] a, logic [15:0] d);
    return {rdy, dn, er, en, we, s, a, d};
  endfunction

  function automatic logic [36:0] obs();
    return pk(mb.req_ready, done, err, mb.bus_en, mb.bus_we, mb.bus_select, mb.bus_addr, mb.bus_data);
  endfunction

  task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    @(negedge clk);
    while (!mb.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!mb.req_ready) chk({tag, " rdy"}, 37'(mb.req_ready), 37'd1);
  endtask

  task automatic drive(input logic [1:0] kind, input logic [1:0] sel, input logic [17:0] addr,
                       input logic [15:0] data);
    mb.req_valid = 1'b1; mb.req_kind = kind; mb.req_select = sel;
    mb.req_addr = addr; mb.req_data = data;
    @(posedge clk);
    #1;
    // Scramble fields so the bench notices if they are not registered at acceptance
    mb.req_valid = 1'b0; mb.req_kind = 2'd3; mb.req_select = ~sel;
    mb.req_addr = ~addr; mb.req_data = ~data;
  endtask

  task automatic xfer(input string tag, input logic [1:0] kind, input logic [1:0] sel,
                      input logic [17:0] addr, input logic [15:0] data, input bit has_pg,
                      input logic [13:0] pg_addr, input logic [15:0] pg_data,
                      input logic [1:0] d_sel, input logic [13:0] d_addr);
    int n;
    logic [36:0] e;
    logic [1:0] s; logic [13:0] a; logic [15:0] d;
    wait_ready(tag);
    drive(kind, sel, addr, data);
    n = has_pg ? 2 * L : L;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c <= n) begin
        if (has_pg && c <= L) begin s = CTRL; a = pg_addr; d = pg_data; end
        else begin s = d_sel; a = d_addr; d = data; end
        e = pk(0, 0, 0, 1, ((c - 1) % L >= 1) && ((c - 1) % L <= WE), s, a, d);
      end else begin
        e = pk(1, 1, 0, 0, 0, d_sel, d_addr, data);
      end
      chk($sformatf("%s c%0d", tag, c), obs(), e);
    end
    last_sel = d_sel; last_addr = d_addr; last_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    mb.req_valid = 1'b0; mb.req_kind = '0; mb.req_select = '0;
    mb.req_addr = '0; mb.req_data = '0;
    repeat (3) @(negedge clk);
    chk("reset", obs(), 37'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle", obs(), pk(1, 0, 0, 0, 0, 2'd0, 14'd0, 16'd0));

    xfer("direct", 2'd0, 2'd1, 18'h0_0005, 16'hABCD, 0, 14'd0, 16'd0, 2'd1, 14'h0005);

    xfer("stm1", 2'd1, 2'd0, 18'h1_4003, 16'h1234, 1, STMR, 16'h0005, STM, 14'h0003);
    xfer("stm2", 2'd1, 2'd0, 18'h1_4004, 16'h4321, !CACHE, STMR, 16'h0005, STM, 14'h0004);

    xfer("duty1", 2'd2, 2'd0, 18'h0_1FFF, 16'h1111, 1, DUTR, 16'h0000, CTRL, 14'h3FFF);
    xfer("duty2", 2'd2, 2'd0, 18'h0_2000, 16'h2222, 1, DUTR, 16'h0001, CTRL, 14'h2000);

    xfer("snoop", 2'd0, CTRL, {4'h0, STMR}, 16'h0007, 0, 14'd0, 16'd0, CTRL, STMR);
    xfer("snooped", 2'd1, 2'd0, 18'h1_C000, 16'h3333, !CACHE, STMR, 16'h0007, STM, 14'h0000);

    xfer("same", 2'd1, 2'd0, 18'h1_C001, 16'h4444, !CACHE, STMR, 16'h0007, STM, 14'h0001);
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    xfer("inval", 2'd1, 2'd0, 18'h1_C002, 16'h5555, 1, STMR, 16'h0007, STM, 14'h0002);

    wait_ready("k3");
    drive(2'd3, 2'd0, 18'h0_0001, 16'hFFFF);
    @(negedge clk);
    chk("k3 c1", obs(), pk(1, 0, 1, 0, 0, last_sel, last_addr, last_data));
    @(negedge clk);
    chk("k3 c2", obs(), pk(1, 0, 0, 0, 0, last_sel, last_addr, last_data));

    wait_ready("rst");
    drive(2'd1, 2'd0, 18'h1_C003, 16'h6666);
    @(negedge clk);
    @(negedge clk);
    chk("rst strobe", 37'({mb.bus_en, mb.bus_we}), 37'b11);
    #2 rst_n = 1'b0;
    #1 chk("rst async", obs(), 37'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_sel = '0; last_addr = '0; last_data = '0;
    xfer("post rst", 2'd1, 2'd0, 18'h1_C004, 16'h7777, 1, STMR, 16'h0007, STM, 14'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
